// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and a size-to-bytes helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  function automatic int bytes_of(size_t s);
    case (s)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Selects the big-endian lanes of a load from the memory word and zero/sign extends them.
module lsu_extract
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]             data_i,
  input  logic [$clog2(N/8)-1:0]   off_i,
  input  logic [1:0]               size_i,
  input  logic                     uns_i,
  output logic [N-1:0]             data_o
);

  localparam int NB = N / 8;

  int           nbytes;
  int           shamt;
  logic [N-1:0] shifted;
  logic [N-1:0] keep;
  logic         sign;

  always_comb begin
    nbytes = bytes_of(size_t'(size_i));
    // Offset 0 is the most significant lane, so the field's LSB sits below the bytes after it.
    shamt = 8 * (NB - int'(off_i) - nbytes);
    if (shamt < 0) shamt = 0;
    shifted = data_i >> shamt;
    keep    = ~({N{1'b1}} << (8 * nbytes));
    sign    = |(shifted & keep & ~(keep >> 1));
    data_o  = (shifted & keep) | ((sign && !uns_i) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: validates a request, drives one handshaked memory access with byte
// enables and replicated store data, and reports completion, errors and ack timeouts.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           store,
  input  logic [1:0]     size,
  input  logic           uns,
  input  logic [N-1:0]   addr,
  input  logic [N-1:0]   wdata,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   rdata,
  output logic           mreq,
  output logic           mwe,
  output logic [N-1:0]   madr,
  output logic [N/8-1:0] mbe,
  output logic [N-1:0]   mwdata,
  input  logic [N-1:0]   mrdata,
  input  logic           mack
);

  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, mreq_q, mreq_d;
  logic          mwe_q, mwe_d, uns_q, uns_d;
  logic [N-1:0]  madr_q, madr_d, mwdata_q, mwdata_d, rdata_q, rdata_d;
  logic [NB-1:0] mbe_q, mbe_d;
  logic [OW-1:0] off_q, off_d;
  size_t         size_q, size_d;
  logic [CW-1:0] cnt_q, cnt_d;

  size_t         req_size;
  int            nbytes;
  logic          legal, aligned;
  logic [NB-1:0] top_mask, be_n;
  logic [N-1:0]  rep_n, ext_data;

  always_comb begin
    req_size = size_t'(size);
    nbytes   = bytes_of(req_size);
    legal    = (req_size != SZ_D) || (N == 64);
    aligned  = (addr[OW-1:0] & OW'(nbytes - 1)) == '0;
    // Enables for offset 0 sit in the top lane; slide the size mask down by the offset.
    top_mask = ~({NB{1'b1}} >> nbytes);
    be_n     = top_mask >> addr[OW-1:0];
    case (req_size)
      SZ_B:    rep_n = {NB{wdata[7:0]}};
      SZ_H:    rep_n = {(NB / 2){wdata[15:0]}};
      SZ_W:    rep_n = {(NB / 4){wdata[31:0]}};
      default: rep_n = wdata;
    endcase
  end

  lsu_extract #(.N(N)) u_extract (
    .data_i (mrdata),
    .off_i  (off_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (ext_data)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a value unassigned (no latches).
    state_d  = state_q;
    mwe_d    = mwe_q;
    madr_d   = madr_q;
    mbe_d    = mbe_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (legal && aligned) begin
            state_d  = REQ;
            mwe_d    = store;
            madr_d   = {addr[N-1:OW], {OW{1'b0}}};
            mbe_d    = be_n;
            mwdata_d = rep_n;
            off_d    = addr[OW-1:0];
            size_d   = req_size;
            uns_d    = uns;
            cnt_d    = '0;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (mack) begin
          state_d = DONE;
          if (!mwe_q) rdata_d = ext_data;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if (TIMEOUT != 0 && cnt_d == TO_VAL) state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
    mreq_d = (state_d == REQ);
    busy_d = mreq_d;
    done_d = (state_d == DONE) || (state_d == ERR);
    err_d  = (state_d == ERR);
  end

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      uns_q    <= 1'b0;
      madr_q   <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      mbe_q    <= '0;
      off_q    <= '0;
      size_q   <= SZ_B;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      uns_q    <= uns_d;
      madr_q   <= madr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      mbe_q    <= mbe_d;
      off_q    <= off_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign mreq   = mreq_q;
  assign mwe    = mwe_q;
  assign madr   = madr_q;
  assign mbe    = mbe_q;
  assign mwdata = mwdata_q;
  assign rdata  = rdata_q;

endmodule
